// File: rtl/bin2oht_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2oht_pipe_if
// Brief    : Stream bundle for bin2oht_pipe (binary index in, one-hot out).
// Revision : 1.0 - initial release
// ============================================================================
interface bin2oht_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    logic                 s_vld;
    logic                 s_rdy;
    logic [WIDTH_LOG-1:0] s_bin;
    logic                 s_ena;
    logic                 m_vld;
    logic                 m_rdy;
    logic [WIDTH-1:0]     m_oht;

    modport master (
        output s_vld, s_bin, s_ena, m_rdy,
        input  s_rdy, m_vld, m_oht
    );

    modport slave (
        input  s_vld, s_bin, s_ena, m_rdy,
        output s_rdy, m_vld, m_oht
    );
endinterface
`default_nettype wire

// File: rtl/bin2oht_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bin2oht_pipe
// Brief    : Pipelined tree binary-to-one-hot decoder, one register stage per
//            SPLIT_LOG-bit digit, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module bin2oht_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    bin2oht_pipe_if.slave bus
);
    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int SPLIT_LOG = $clog2(SPLIT);
    localparam int LEVELS    = (SPLIT_LOG > 0) ? (WIDTH_LOG / SPLIT_LOG) : 1;

    if ((SPLIT < 2) || ((SPLIT & (SPLIT - 1)) != 0) || (WIDTH != SPLIT ** LEVELS)) begin : g_param_check
        $fatal(1, "bin2oht_pipe: WIDTH must equal SPLIT**LEVELS, SPLIT a power of two >= 2");
    end

    for (genvar i = 0; i < LEVELS; i++) begin : g_stage
        localparam int OW = SPLIT ** (i + 1);          // one-hot bits held here
        localparam int IW = OW / SPLIT;                // one-hot bits from parent
        localparam int RW = (LEVELS - i - 1) * SPLIT_LOG;

        logic                    r_vld;
        logic [OW-1:0]           r_oht;
        logic                    w_vld_in;
        logic                    w_rdy;
        logic                    w_rdy_dn;
        logic [IW-1:0]           w_par;
        logic [RW+SPLIT_LOG-1:0] w_bin;
        logic [OW-1:0]           w_oht_nxt;

        // Stage 1 sees the enable as a single-bit parent one-hot.
        if (i == 0) begin : g_src_in
            assign w_vld_in = bus.s_vld;
            assign w_par    = bus.s_ena;
            assign w_bin    = bus.s_bin;
        end else begin : g_src_stage
            assign w_vld_in = g_stage[i-1].r_vld;
            assign w_par    = g_stage[i-1].r_oht;
            assign w_bin    = g_stage[i-1].g_rem.r_rem;
        end

        if (i == LEVELS - 1) begin : g_rdy_out
            assign w_rdy_dn = bus.m_rdy;
        end else begin : g_rdy_stage
            assign w_rdy_dn = g_stage[i+1].w_rdy;
        end

        // An empty stage always accepts, so bubbles collapse under stall.
        assign w_rdy = ~r_vld | w_rdy_dn;

        always_comb begin
            w_oht_nxt = '0;
            for (int p = 0; p < IW; p++) begin
                for (int j = 0; j < SPLIT; j++) begin
                    w_oht_nxt[p*SPLIT+j] = w_par[p]
                        & (w_bin[RW+SPLIT_LOG-1 -: SPLIT_LOG] == SPLIT_LOG'(j));
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_oht <= '0;
            end else if (w_rdy) begin
                r_vld <= w_vld_in;
                if (w_vld_in) begin
                    r_oht <= w_oht_nxt;
                end
            end
        end

        if (RW > 0) begin : g_rem
            logic [RW-1:0] r_rem;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rem <= '0;
                end else if (w_rdy && w_vld_in) begin
                    r_rem <= w_bin[RW-1:0];
                end
            end
        end
    end

    assign bus.s_rdy = g_stage[0].w_rdy;
    assign bus.m_vld = g_stage[LEVELS-1].r_vld;
    assign bus.m_oht = g_stage[LEVELS-1].r_oht;
endmodule
`default_nettype wire

// File: tb/tb_bin2oht_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2oht_pipe
// Brief    : Self-checking bench for bin2oht_pipe (32/2 and 16/4 variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2oht_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin2oht_pipe_if #(.WIDTH(32)) a_if ();
    bin2oht_pipe_if #(.WIDTH(16)) b_if ();

    bin2oht_pipe #(.WIDTH(32), .SPLIT(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    bin2oht_pipe #(.WIDTH(16), .SPLIT(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    typedef struct {
        logic [4:0]  bin;
        logic        ena;
        logic [31:0] exp;
    } vec_t;

    vec_t        tab[8];
    logic [31:0] qa[$];
    logic [15:0] qb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        mon_en  = 1'b0;
    int          occ_a, occ_b;
    logic        stall_a, stall_b;
    logic [31:0] prev_a;
    logic [15:0] prev_b;
    int          beats_a = 0;
    int          first_a = 0;
    int          last_a  = 0;
    logic        bp_done;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
        end
    endfunction

    function automatic void flag(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Output monitor: scoreboard pop, stall stability and ready-vs-occupancy model.
    always @(negedge clk) begin
        cyc++;
        if (rst || !mon_en) begin
            occ_a = 0; occ_b = 0; stall_a = 1'b0; stall_b = 1'b0;
        end else begin
            check("a_s_rdy_vs_occupancy", 32'(a_if.s_rdy), 32'(!(occ_a == 5 && !a_if.m_rdy)));
            check("b_s_rdy_vs_occupancy", 32'(b_if.s_rdy), 32'(!(occ_b == 2 && !b_if.m_rdy)));
            if (stall_a) begin
                check("a_stall_vld", 32'(a_if.m_vld), 32'd1);
                check("a_stall_oht", a_if.m_oht, prev_a);
            end
            if (stall_b) begin
                check("b_stall_vld", 32'(b_if.m_vld), 32'd1);
                check("b_stall_oht", 32'(b_if.m_oht), 32'(prev_b));
            end
            if (a_if.m_vld && a_if.m_rdy) begin
                if (qa.size() == 0) flag("a_unexpected_beat", $sformatf("beat 0x%h with nothing pending", a_if.m_oht));
                else check("a_oht", a_if.m_oht, qa.pop_front());
                beats_a++;
                if (beats_a == 1) first_a = cyc;
                last_a = cyc;
            end
            if (b_if.m_vld && b_if.m_rdy) begin
                if (qb.size() == 0) flag("b_unexpected_beat", $sformatf("beat 0x%h with nothing pending", b_if.m_oht));
                else check("b_oht", 32'(b_if.m_oht), 32'(qb.pop_front()));
            end
            stall_a = a_if.m_vld && !a_if.m_rdy;
            stall_b = b_if.m_vld && !b_if.m_rdy;
            prev_a  = a_if.m_oht;
            prev_b  = b_if.m_oht;
            if (a_if.s_vld && a_if.s_rdy) occ_a++;
            if (a_if.m_vld && a_if.m_rdy) occ_a--;
            if (b_if.s_vld && b_if.s_rdy) occ_b++;
            if (b_if.m_vld && b_if.m_rdy) occ_b--;
        end
    end

    // Called and returning at posedge+1; s_vld is left high for back-to-back use.
    task automatic send_a(input logic [4:0] bin, input logic ena, input logic [31:0] exp);
        int guard = 0;
        a_if.s_vld = 1'b1; a_if.s_bin = bin; a_if.s_ena = ena;
        @(negedge clk);
        while (!a_if.s_rdy && guard < 100) begin @(negedge clk); guard++; end
        if (a_if.s_rdy) qa.push_back(exp);
        else flag("a_send_timeout", "s_rdy stuck at 0, required 1");
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [3:0] bin, input logic ena, input logic [15:0] exp);
        int guard = 0;
        b_if.s_vld = 1'b1; b_if.s_bin = bin; b_if.s_ena = ena;
        @(negedge clk);
        while (!b_if.s_rdy && guard < 100) begin @(negedge clk); guard++; end
        if (b_if.s_rdy) qb.push_back(exp);
        else flag("b_send_timeout", "s_rdy stuck at 0, required 1");
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int guard = 0;
        while ((qa.size() != 0 || qb.size() != 0) && guard < 300) begin @(posedge clk); #1; guard++; end
        if (qa.size() != 0 || qb.size() != 0) begin
            flag("drain_timeout", $sformatf("%0d/%0d items still pending, required 0", qa.size(), qb.size()));
            qa.delete(); qb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits, lat, c0, beats0;

        tab[0] = '{5'd19, 1'b1, 32'h0008_0000};
        tab[1] = '{5'd7,  1'b0, 32'h0000_0000};
        tab[2] = '{5'd7,  1'b1, 32'h0000_0080};
        tab[3] = '{5'd0,  1'b1, 32'h0000_0001};
        tab[4] = '{5'd31, 1'b1, 32'h8000_0000};
        tab[5] = '{5'd16, 1'b1, 32'h0001_0000};
        tab[6] = '{5'd31, 1'b0, 32'h0000_0000};
        tab[7] = '{5'd10, 1'b1, 32'h0000_0400};

        rst = 1'b1;
        a_if.s_vld = 1'b0; a_if.s_bin = '0; a_if.s_ena = 1'b0; a_if.m_rdy = 1'b1;
        b_if.s_vld = 1'b0; b_if.s_bin = '0; b_if.s_ena = 1'b0; b_if.m_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; mon_en = 1'b1;

        @(negedge clk);
        check("rst_a_m_vld", 32'(a_if.m_vld), 32'd0);
        check("rst_a_m_oht", a_if.m_oht, 32'd0);
        check("rst_a_s_rdy", 32'(a_if.s_rdy), 32'd1);
        check("rst_b_m_vld", 32'(b_if.m_vld), 32'd0);
        check("rst_b_m_oht", 32'(b_if.m_oht), 32'd0);
        @(posedge clk); #1;

        // Single-transfer latency on both variants.
        send_a(5'd19, 1'b1, 32'h0008_0000);
        a_if.s_vld = 1'b0;
        hits = 0; lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_if.m_vld) begin hits++; lat = c; end
        end
        check("a_latency", 32'(lat), 32'd5);
        check("a_single_beat", 32'(hits), 32'd1);
        @(posedge clk); #1;

        send_b(4'hB, 1'b1, 16'h0800);
        b_if.s_vld = 1'b0;
        hits = 0; lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (b_if.m_vld) begin hits++; lat = c; end
        end
        check("b_latency", 32'(lat), 32'd2);
        check("b_single_beat", 32'(hits), 32'd1);
        @(posedge clk); #1;

        // Table vectors, including ena=0 followed by ena=1 on the same index.
        for (int i = 0; i < 8; i++) send_a(tab[i].bin, tab[i].ena, tab[i].exp);
        a_if.s_vld = 1'b0;
        drain();

        // Back-to-back sweep: no input stalls, 32 consecutive output beats.
        beats_a = 0;
        c0 = cyc;
        for (int i = 0; i < 32; i++) send_a(5'(i), 1'b1, 32'h1 << i);
        a_if.s_vld = 1'b0;
        check("a_sweep_input_cycles", 32'(cyc - c0), 32'd32);
        drain();
        check("a_sweep_beats", 32'(beats_a), 32'd32);
        check("a_sweep_contiguous", 32'(last_a - first_a), 32'd31);

        // Random 50% backpressure while streaming 0..9.
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_a(5'(i), 1'b1, 32'h1 << i);
                a_if.s_vld = 1'b0;
                drain();
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    a_if.m_rdy = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                a_if.m_rdy = 1'b1;
            end
        join

        // Fill a stalled pipeline, then transfer in and out together while full.
        a_if.m_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send_a(5'(20 + i), 1'b1, 32'h1 << (20 + i));
        a_if.s_bin = 5'd25;
        @(negedge clk);
        check("a_full_s_rdy", 32'(a_if.s_rdy), 32'd0);
        check("a_full_m_vld", 32'(a_if.m_vld), 32'd1);
        check("a_full_m_oht", a_if.m_oht, 32'h0010_0000);
        @(posedge clk); #1;
        a_if.s_vld = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        a_if.m_rdy = 1'b1;
        send_a(5'd25, 1'b1, 32'h0200_0000);
        a_if.s_vld = 1'b0; a_if.m_rdy = 1'b0;
        @(negedge clk);
        check("a_still_full_s_rdy", 32'(a_if.s_rdy), 32'd0);
        check("a_still_full_m_oht", a_if.m_oht, 32'h0020_0000);
        @(posedge clk); #1;
        a_if.m_rdy = 1'b1;
        drain();

        // Reset with three items in flight and a simultaneous input offer.
        send_a(5'd1, 1'b1, 32'h2);
        send_a(5'd2, 1'b1, 32'h4);
        send_a(5'd3, 1'b1, 32'h8);
        a_if.s_bin = 5'd9; a_if.s_ena = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_if.s_vld = 1'b0;
        qa.delete();
        beats0 = beats_a;
        @(negedge clk);
        check("rst_mid_m_vld", 32'(a_if.m_vld), 32'd0);
        check("rst_mid_m_oht", a_if.m_oht, 32'd0);
        check("rst_mid_s_rdy", 32'(a_if.s_rdy), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check("rst_mid_no_stale", 32'(beats_a - beats0), 32'd0);

        // Exhaustive 16/4 variant.
        for (int i = 0; i < 16; i++) send_b(4'(i), 1'b1, 16'h1 << i);
        send_b(4'd5, 1'b0, 16'h0000);
        b_if.s_vld = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bin2oht_pipe.md
Name: bin2oht_pipe

Overview:
- Pipelined binary-to-one-hot decoder. The inverse of the team's tree one-hot encoder.
- Decodes SPLIT_LOG binary bits per tree level, with one register stage per level.
- Has valid/ready handshakes on both sides, so it can sit between streaming producers and consumers, e.g. arbiter grant expansion or write-enable fan-out.
- Full throughput: one decode per cycle when not back-pressured.

Parameters:
- WIDTH, 32, one-hot output width. Must equal SPLIT**LEVELS.
- SPLIT, 2, tree radix. Power of two, at least 2.
- WIDTH_LOG (local), $clog2(WIDTH), binary width.
- SPLIT_LOG (local), $clog2(SPLIT), bits decoded per level.
- LEVELS (local), WIDTH_LOG/SPLIT_LOG, number of tree levels and pipeline stages.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_vld  input  1  input transfer valid.
- s_rdy  output  1  input transfer ready.
- s_bin  input  WIDTH_LOG  binary index.
- s_ena  input  1  decode enable. 0 produces an all-zero one-hot.
- m_vld  output  1  output transfer valid.
- m_rdy  input  1  output transfer ready.
- m_oht  output  WIDTH  one-hot result, or zero when ena=0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Parameter elaboration: fatal error if WIDTH != SPLIT**LEVELS, or SPLIT is not a power of two, or SPLIT < 2.
- Transfers:
  - An input transfer occurs on a cycle with s_vld & s_rdy.
  - An output transfer occurs on a cycle with m_vld & m_rdy.
- Stage k, for k = 1..LEVELS, holds:
  - vld_k;
  - oht_k, SPLIT**k bits;
  - rem_k, the remaining low binary bits, (LEVELS-k)*SPLIT_LOG bits. Stage LEVELS has no rem.
- Stage 1 load:
  - digit d = s_bin[WIDTH_LOG-1 -: SPLIT_LOG].
  - oht_1[j] = s_ena & (d == j).
  - rem_1 = remaining low bits of s_bin.
- Stage k>1 load:
  - digit d = top SPLIT_LOG bits of rem_{k-1}.
  - oht_k[i*SPLIT+j] = oht_{k-1}[i] & (d == j).
  - rem_k = rem_{k-1} shifted left by SPLIT_LOG (top digit dropped).
- Outputs: m_oht = oht_LEVELS, m_vld = vld_LEVELS.
- Ready chain:
  - rdy_k = ~vld_k | rdy_{k+1}, with rdy_{LEVELS+1} = m_rdy.
  - s_rdy = rdy_1.
  - Combinational path from m_rdy to s_rdy is permitted.
- Stage update when rdy_k = 1:
  - vld_k <= vld_{k-1}, with vld_0 = s_vld.
  - Data registers load only if the incoming valid is 1; otherwise data holds.
- Latency: exactly LEVELS cycles from input transfer to m_vld, when m_rdy stays 1.
- Throughput: 1 transfer/cycle. Up to LEVELS transfers in flight; no bubbles inserted.
- Stall: while m_vld & ~m_rdy:
  - m_oht and m_vld hold stable;
  - upstream stages fill until all are valid, after which s_rdy = 0.
- Bubbles collapse: an empty stage always accepts, regardless of m_rdy.
- Order preserved; no item dropped or duplicated.
- Output invariant: m_oht has exactly one bit set, at index s_bin, when ena=1; it is all-zero when ena=0.
- Reset:
  - all vld_k = 0, all oht_k = 0, all rem_k = 0;
  - hence m_vld = 0, m_oht = 0, s_rdy = 1 in the cycle after reset.
  - Reset mid-stream discards all in-flight items; none emerge after reset.
  - Reset overrides a simultaneous input transfer.
- Simultaneous input and output transfer on a full pipeline is legal: the pipeline advances by one and stays full.

Test Plan:
- Single transfer, WIDTH=32/SPLIT=2, s_bin=5'd19, s_ena=1, m_rdy=1 -> m_vld=1 exactly 5 cycles later with m_oht=32'h0008_0000; m_vld=0 on all other cycles.
- Back-to-back sweep of s_bin=0..31 with ena=1 and m_rdy=1 -> 32 consecutive output beats, m_oht=1<<i in order, s_rdy constantly 1.
- Backpressure: stream 0..9 with m_rdy toggled by a random 50% pattern -> outputs 1<<0..1<<9 in order; m_oht stable during every stall; s_rdy=0 once 5 items are pending.
- s_ena=0 with s_bin=7 -> one beat with m_oht=0, m_vld=1; then s_ena=1, s_bin=7 -> m_oht=32'h80.
- Reset mid-operation: 3 items in flight, rst asserted 1 cycle -> next cycle m_vld=0, m_oht=0, s_rdy=1; no stale beats afterwards.
- Variant WIDTH=16/SPLIT=4, s_bin=4'hB -> latency 2 cycles, m_oht=16'h0800. Exhaustive 0..15 matches 1<<s_bin.
